// File: rtl/sequencer_row.sv
// Row-level sequencer that keeps a sorted key array and runs LOAD/SCAN/INSERT/DELETE on it.
// Define SEQROW_EARLY_EXIT_EN to end the compare phase at the first group holding a qualifying key.
module sequencer_row #(
    parameter int CELL_SIZE  = 8,
    parameter int ITEM_CELLS = 4,
    parameter int ITEMS      = 16,
    parameter int LANES      = 4,
    localparam int KEY_W     = CELL_SIZE * ITEM_CELLS,
    localparam int ROW_W     = KEY_W * ITEMS,
    localparam int IDXW      = $clog2(ITEMS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_code,
    input  logic [KEY_W-1:0] target,
    input  logic [ROW_W-1:0] row_i,
    input  logic [IDXW-1:0]  cnt_i,
    output logic [ROW_W-1:0] row_o,
    output logic [IDXW-1:0]  cnt_o,
    output logic             done,
    output logic             hit,
    output logic [IDXW-1:0]  ins_pt,
    output logic             ovf,
    output logic [KEY_W-1:0] ovf_item
);

    localparam int NGRP = ITEMS / LANES;
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CMP   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [1:0] OP_LOAD   = 2'd0;
    localparam logic [1:0] OP_SCAN   = 2'd1;
    localparam logic [1:0] OP_INSERT = 2'd2;
    localparam logic [1:0] OP_DELETE = 2'd3;

    logic [1:0]       state;
    logic [1:0]       op_q;
    logic [KEY_W-1:0] tgt_q;
    logic [GW-1:0]    grp;
    logic             found_q;
    logic             hitw_q;
    logic [IDXW-1:0]  insw_q;
    logic             run_q;

    logic             lane_hit;
    logic             lane_eq;
    logic [IDXW-1:0]  lane_idx;
    int               idx;
    int               ngrp;
    logic             last_grp;
    logic             cmp_end;
    logic [IDXW-1:0]  ins_fin;
    logic             hit_fin;

    logic [ROW_W-1:0] new_row;
    logic [IDXW-1:0]  new_cnt;
    logic             new_ovf;
    logic [KEY_W-1:0] new_ovf_item;

    assign op_ready = (state == S_IDLE) && run_q;

    // One lane group per cycle; the lowest qualifying lane wins.
    always_comb begin
        lane_hit = 1'b0;
        lane_eq  = 1'b0;
        lane_idx = '0;
        idx      = 0;
        for (int l = LANES - 1; l >= 0; l--) begin
            idx = int'(grp) * LANES + l;
            if (idx < int'(cnt_o) && row_o[idx*KEY_W +: KEY_W] >= tgt_q) begin
                lane_hit = 1'b1;
                lane_eq  = (row_o[idx*KEY_W +: KEY_W] == tgt_q);
                lane_idx = IDXW'(idx);
            end
        end
        ngrp = (int'(cnt_o) + LANES - 1) / LANES;
        if (ngrp == 0) ngrp = 1;
        last_grp = (int'(grp) == ngrp - 1);
        if (found_q) begin
            ins_fin = insw_q;
            hit_fin = hitw_q;
        end else if (lane_hit) begin
            ins_fin = lane_idx;
            hit_fin = lane_eq;
        end else begin
            ins_fin = cnt_o;
            hit_fin = 1'b0;
        end
    end

`ifdef SEQROW_EARLY_EXIT_EN
    assign cmp_end = last_grp || lane_hit;
`else
    assign cmp_end = last_grp;
`endif

    // Row rewrite for INSERT/DELETE; slots above cnt are already all-ones.
    always_comb begin
        new_row      = row_o;
        new_cnt      = cnt_o;
        new_ovf      = 1'b0;
        new_ovf_item = '0;
        if (op_q == OP_INSERT) begin
            if (int'(cnt_o) == ITEMS) begin
                new_ovf      = 1'b1;
                new_ovf_item = (int'(insw_q) == ITEMS) ? tgt_q : row_o[ROW_W-1 -: KEY_W];
            end else begin
                new_cnt = cnt_o + IDXW'(1);
            end
            if (int'(insw_q) < ITEMS) begin
                for (int i = 1; i < ITEMS; i++) begin
                    if (i > int'(insw_q)) new_row[i*KEY_W +: KEY_W] = row_o[(i-1)*KEY_W +: KEY_W];
                end
                new_row[int'(insw_q)*KEY_W +: KEY_W] = tgt_q;
            end
        end else if (op_q == OP_DELETE && hitw_q) begin
            new_cnt = cnt_o - IDXW'(1);
            for (int i = 0; i < ITEMS - 1; i++) begin
                if (i >= int'(insw_q)) new_row[i*KEY_W +: KEY_W] = row_o[(i+1)*KEY_W +: KEY_W];
            end
            new_row[ROW_W-1 -: KEY_W] = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            run_q    <= 1'b0;
            op_q     <= OP_LOAD;
            tgt_q    <= '0;
            grp      <= '0;
            found_q  <= 1'b0;
            hitw_q   <= 1'b0;
            insw_q   <= '0;
            row_o    <= '1;
            cnt_o    <= '0;
            done     <= 1'b0;
            hit      <= 1'b0;
            ins_pt   <= '0;
            ovf      <= 1'b0;
            ovf_item <= '0;
        end else begin
            run_q <= 1'b1;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_valid && op_ready) begin
                        op_q    <= op_code;
                        tgt_q   <= target;
                        grp     <= '0;
                        found_q <= 1'b0;
                        hitw_q  <= 1'b0;
                        insw_q  <= '0;
                        if (op_code == OP_LOAD) begin
                            row_o    <= row_i;
                            cnt_o    <= (int'(cnt_i) > ITEMS) ? IDXW'(ITEMS) : cnt_i;
                            hit      <= 1'b0;
                            ins_pt   <= '0;
                            ovf      <= 1'b0;
                            ovf_item <= '0;
                            done     <= 1'b1;
                            state    <= S_FIN;
                        end else begin
                            state <= S_CMP;
                        end
                    end
                end
                S_CMP: begin
                    if (!found_q && lane_hit) begin
                        found_q <= 1'b1;
                        hitw_q  <= lane_eq;
                        insw_q  <= lane_idx;
                    end
                    if (cmp_end) begin
                        if (op_q == OP_SCAN) begin
                            hit      <= hit_fin;
                            ins_pt   <= ins_fin;
                            ovf      <= 1'b0;
                            ovf_item <= '0;
                            done     <= 1'b1;
                            state    <= S_FIN;
                        end else begin
                            hitw_q <= hit_fin;
                            insw_q <= ins_fin;
                            state  <= S_SHIFT;
                        end
                    end else begin
                        grp <= grp + GW'(1);
                    end
                end
                S_SHIFT: begin
                    row_o    <= new_row;
                    cnt_o    <= new_cnt;
                    hit      <= hitw_q;
                    ins_pt   <= insw_q;
                    ovf      <= new_ovf;
                    ovf_item <= new_ovf_item;
                    done     <= 1'b1;
                    state    <= S_FIN;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sequencer_row.sv
// Bench for sequencer_row (4 one-byte keys, 2 lanes) against a queue-based model of the sorted row.
module tb_sequencer_row;

    localparam int IT = 4;
    localparam int LN = 2;
    localparam int KW = 8;
    localparam int RW = 32;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [1:0]    op_code = 2'd0;
    logic [KW-1:0] target = '0;
    logic [RW-1:0] row_i = '0;
    logic [IW-1:0] cnt_i = '0;
    logic [RW-1:0] row_o;
    logic [IW-1:0] cnt_o;
    logic          done;
    logic          hit;
    logic [IW-1:0] ins_pt;
    logic          ovf;
    logic [KW-1:0] ovf_item;

    sequencer_row #(.CELL_SIZE(8), .ITEM_CELLS(1), .ITEMS(IT), .LANES(LN)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .target(target), .row_i(row_i), .cnt_i(cnt_i),
        .row_o(row_o), .cnt_o(cnt_o), .done(done), .hit(hit), .ins_pt(ins_pt),
        .ovf(ovf), .ovf_item(ovf_item)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] mq[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_row();
        logic [31:0] r;
        r = '1;
        for (int i = 0; i < mq.size(); i++) r[i*8 +: 8] = mq[i];
        return r;
    endfunction

    task automatic issue(input logic [1:0] code, input logic [7:0] t, input logic [31:0] r, input int c);
        int cnt0, ins, g, exp_lat, lat, n;
        logic ehit, eovf;
        logic [7:0] eitem;
        bit seen;
        @(negedge clk);
        check("done_low_idle", done, 0);
        check("op_ready_idle", op_ready, 1);
        op_valid = 1'b1; op_code = code; target = t; row_i = r; cnt_i = c[2:0];
        @(posedge clk);
        #1;
        op_valid = 1'b0; target = $urandom; row_i = $urandom; cnt_i = $urandom;
        cnt0 = mq.size(); ehit = 0; eovf = 0; eitem = 0; ins = 0;
        if (code == 2'd0) begin
            mq.delete();
            n = (c > IT) ? IT : c;
            for (int i = 0; i < n; i++) mq.push_back(r[i*8 +: 8]);
            exp_lat = 1;
        end else begin
            ins = cnt0;
            for (int i = cnt0 - 1; i >= 0; i--) if (mq[i] >= t) ins = i;
            ehit = (ins < cnt0) && (mq[ins] == t);
            g = (cnt0 == 0) ? 1 : (cnt0 + LN - 1) / LN;
`ifdef SEQROW_EARLY_EXIT_EN
            if (ins < cnt0) g = ins / LN + 1;
`endif
            exp_lat = (code == 2'd1) ? 1 + g : 2 + g;
            if (code == 2'd2) begin
                mq.insert(ins, t);
                if (mq.size() > IT) begin
                    eovf = 1;
                    eitem = mq.pop_back();
                end
            end
            if (code == 2'd3 && ehit) mq.delete(ins);
        end
        lat = 0; seen = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (done) seen = 1;
            else begin
                check("op_ready_busy", op_ready, 0);
                op_valid = 1'($urandom_range(0, 1)); op_code = 2'($urandom); target = $urandom;
            end
        end
        op_valid = 1'b0;
        check("latency", lat, exp_lat);
        check("op_ready_done", op_ready, 0);
        check("row_o", row_o, model_row());
        check("cnt_o", cnt_o, mq.size());
        check("hit", hit, ehit);
        check("ins_pt", ins_pt, ins);
        check("ovf", ovf, eovf);
        if (eovf) check("ovf_item", ovf_item, eitem);
    endtask

    initial begin
        logic [7:0] vals[$];
        logic [31:0] r;
        int n, c;
        logic [1:0] code;

        repeat (3) @(negedge clk);
        check("rst_row", row_o, 32'hFFFF_FFFF);
        check("rst_cnt", cnt_o, 0);
        check("rst_done", done, 0);
        check("rst_hit", hit, 0);
        check("rst_ins", ins_pt, 0);
        check("rst_ovf", ovf, 0);
        check("rst_item", ovf_item, 0);
        check("rst_ready", op_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", op_ready, 1);

        issue(2'd0, 8'h00, 32'hFF30_2010, 3);
        issue(2'd1, 8'h20, 32'h0, 0);
        check("scan20_hit", hit, 1);
        check("scan20_ins", ins_pt, 1);
        issue(2'd2, 8'h25, 32'h0, 0);
        check("ins25_row", row_o, 32'h3025_2010);
        issue(2'd2, 8'h05, 32'h0, 0);
        check("ins05_row", row_o, 32'h2520_1005);
        check("ins05_item", ovf_item, 8'h30);
        issue(2'd2, 8'h40, 32'h0, 0);
        check("ins40_item", ovf_item, 8'h40);
        check("ins40_ins", ins_pt, 4);
        issue(2'd3, 8'h20, 32'h0, 0);
        check("del20_row", row_o, 32'hFF25_1005);
        issue(2'd3, 8'h99, 32'h0, 0);
        check("del99_ins", ins_pt, 3);

        // Reset while a SCAN is in flight.
        @(negedge clk);
        check("ready_pre_abort", op_ready, 1);
        op_valid = 1'b1; op_code = 2'd1; target = 8'h25;
        @(posedge clk);
        #1;
        op_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("abort_done_t1", done, 0);
        @(negedge clk);
        check("abort_done", done, 0);
        check("abort_cnt", cnt_o, 0);
        check("abort_row", row_o, 32'hFFFF_FFFF);
        check("abort_ready_low", op_ready, 0);
        rst_n = 1'b1;
        mq.delete();
        @(negedge clk);
        check("abort_ready_high", op_ready, 1);
        issue(2'd0, 8'h00, 32'h0403_0201, 7);
        check("load_clamp", cnt_o, 4);
        issue(2'd1, 8'h00, 32'h0, 0);
        issue(2'd0, 8'h00, 32'hFFFF_FFFF, 0);
        issue(2'd1, 8'h10, 32'h0, 0);
        issue(2'd3, 8'h10, 32'h0, 0);

        for (int k = 0; k < 120; k++) begin
            code = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) code = 2'd0;
            if (code == 2'd0) begin
                vals.delete();
                n = $urandom_range(0, IT);
                for (int i = 0; i < n; i++) vals.push_back(8'($urandom_range(0, 7) * 16));
                vals.sort();
                r = '1;
                for (int i = 0; i < n; i++) r[i*8 +: 8] = vals[i];
                c = (n == IT) ? $urandom_range(IT, 7) : n;
                issue(code, 8'h00, r, c);
            end else begin
                issue(code, 8'($urandom_range(0, 8) * 16), 32'h0, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
